// File: rtl/router_reg_param.sv
// Purpose: router datapath register: latches header, forwards bytes to the port FIFOs, checks parity and payload length.
// Latency: data_in to dout 1 cycle; header on dout the cycle after lfd_state; err/len_err 1 cycle after parity_done.
// Backpressure: while fifo_full in LOAD_DATA the byte is parked in hold_reg and replayed on laf_state.
module router_reg_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 2,
    parameter int NUM_PORTS  = 3,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  lfd_state,
    input  logic                  rst_int_reg,
    output logic                  err,
    output logic                  len_err,
    output logic                  parity_done,
    output logic                  low_packet_valid,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int LEN_W = DATA_WIDTH - ADDR_BITS;
    localparam int CNT_W = LEN_W + 1;
    localparam logic [DATA_WIDTH-1:0] SEED = (PARITY_ODD != 0) ? '1 : '0;

    typedef struct packed {
        logic [LEN_W-1:0]     len;
        logic [ADDR_BITS-1:0] addr;
    } hdr_t;

    hdr_t                  header_reg;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic [DATA_WIDTH-1:0] int_parity;
    logic [DATA_WIDTH-1:0] pkt_parity;
    logic [CNT_W-1:0]      byte_cnt;
    logic                  parity_done_d;

    logic addr_ok;
    logic payload_vld;
    logic parity_cap;
    logic check_vld;

    // Extra MSB keeps the compare correct when NUM_PORTS == 2**ADDR_BITS.
    assign addr_ok     = {1'b0, data_in[ADDR_BITS-1:0]} < (ADDR_BITS + 1)'(NUM_PORTS);
    assign payload_vld = ld_state & pkt_valid & ~full_state;
    assign parity_cap  = (ld_state & ~fifo_full & ~pkt_valid) |
                         (laf_state & low_packet_valid & ~parity_done);
    assign check_vld   = parity_done & ~parity_done_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            header_reg <= '0;
        end else if (detect_add & pkt_valid & addr_ok) begin
            header_reg <= data_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout     <= '0;
            hold_reg <= '0;
        end else if (lfd_state) begin
            dout <= header_reg;
        end else if (ld_state & ~fifo_full) begin
            dout <= data_in;
        end else if (ld_state & fifo_full) begin
            hold_reg <= data_in;
        end else if (laf_state) begin
            dout <= hold_reg;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            int_parity <= SEED;
            byte_cnt   <= '0;
        end else if (detect_add) begin
            int_parity <= SEED;
            byte_cnt   <= '0;
        end else if (lfd_state) begin
            int_parity <= int_parity ^ header_reg;
        end else if (payload_vld) begin
            int_parity <= int_parity ^ data_in;
            if (byte_cnt != '1) begin
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pkt_parity  <= '0;
            parity_done <= 1'b0;
        end else begin
            if (parity_cap) begin
                pkt_parity <= data_in;
            end
            if (detect_add) begin
                parity_done <= 1'b0;
            end else if (parity_cap) begin
                parity_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            low_packet_valid <= 1'b0;
        end else if (ld_state & ~pkt_valid) begin
            low_packet_valid <= 1'b1;
        end else if (rst_int_reg) begin
            low_packet_valid <= 1'b0;
        end
    end

    // Checks fire once, on the cycle after the parity byte is captured.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity_done_d <= 1'b0;
            err           <= 1'b0;
            len_err       <= 1'b0;
        end else begin
            parity_done_d <= parity_done;
            if (detect_add) begin
                err     <= 1'b0;
                len_err <= 1'b0;
            end else if (check_vld) begin
                err     <= (int_parity != pkt_parity);
                len_err <= (byte_cnt != {1'b0, header_reg.len});
            end
        end
    end

endmodule

// File: tb/tb_router_reg_param.sv
// Directed bench for router_reg_param: an even-parity and an odd-parity instance share one stimulus stream.
module tb_router_reg_param;

    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid, fifo_full, detect_add, ld_state, laf_state, full_state, lfd_state, rst_int_reg;
    logic [7:0] data_in;
    logic       err, len_err, parity_done, low_packet_valid;
    logic [7:0] dout;
    logic       err_o, len_err_o, parity_done_o, low_packet_valid_o;
    logic [7:0] dout_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] pl [0:7];

    always #5 clock = ~clock;

    router_reg_param #(.DATA_WIDTH(8), .ADDR_BITS(2), .NUM_PORTS(3), .PARITY_ODD(0)) dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .detect_add(detect_add), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .lfd_state(lfd_state),
        .rst_int_reg(rst_int_reg), .err(err), .len_err(len_err),
        .parity_done(parity_done), .low_packet_valid(low_packet_valid), .dout(dout)
    );

    router_reg_param #(.DATA_WIDTH(8), .ADDR_BITS(2), .NUM_PORTS(3), .PARITY_ODD(1)) dut_odd (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .detect_add(detect_add), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .lfd_state(lfd_state),
        .rst_int_reg(rst_int_reg), .err(err_o), .len_err(len_err_o),
        .parity_done(parity_done_o), .low_packet_valid(low_packet_valid_o), .dout(dout_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock with the given strobes; returns #1 after the rising edge.
    task automatic cyc(input logic da, input logic lfd, input logic ld, input logic laf,
                       input logic fs, input logic rir, input logic pv, input logic ff,
                       input logic [7:0] d);
        detect_add = da; lfd_state = lfd; ld_state = ld; laf_state = laf;
        full_state = fs; rst_int_reg = rir; pkt_valid = pv; fifo_full = ff; data_in = d;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    // Full packet walk: DECODE, LFD, n payload bytes (optional stall at full_at), parity, CHECK_PARITY.
    task automatic send_pkt(input string name, input logic [7:0] hdr, input int n,
                            input logic [7:0] par, input int full_at,
                            input logic exp_err, input logic exp_len, input logic exp_err_o);
        logic [7:0] last;
        cyc(1, 0, 0, 0, 0, 0, 1, 0, hdr);
        chk({name, "_clr_err"}, err, 0);
        chk({name, "_clr_done"}, parity_done, 0);
        cyc(0, 1, 0, 0, 0, 0, 1, 0, hdr);
        chk({name, "_hdr_dout"}, dout, hdr);
        last = hdr;
        for (int i = 0; i < n; i++) begin
            if (i == full_at) begin
                cyc(0, 0, 1, 0, 0, 0, 1, 1, pl[i]);
                chk({name, "_stall_hold"}, dout, last);
                cyc(0, 0, 0, 0, 1, 0, 1, 1, pl[i]);
                chk({name, "_full_hold"}, dout, last);
                cyc(0, 0, 0, 1, 0, 0, 1, 0, pl[i]);
                chk({name, "_laf_dout"}, dout, pl[i]);
            end else begin
                cyc(0, 0, 1, 0, 0, 0, 1, 0, pl[i]);
                chk({name, "_pl_dout"}, dout, pl[i]);
            end
            last = pl[i];
        end
        cyc(0, 0, 1, 0, 0, 0, 0, 0, par);
        chk({name, "_par_dout"}, dout, par);
        chk({name, "_par_done"}, parity_done, 1);
        chk({name, "_lpv_set"}, low_packet_valid, 1);
        chk({name, "_err_early"}, err, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
        chk({name, "_lpv_clr"}, low_packet_valid, 0);
        chk({name, "_err"}, err, exp_err);
        chk({name, "_len_err"}, len_err, exp_len);
        chk({name, "_err_odd"}, err_o, exp_err_o);
        chk({name, "_len_err_odd"}, len_err_o, exp_len);
        idle();
        chk({name, "_err_sticky"}, err, exp_err);
    endtask

    initial begin
        reset = 1'b1;
        detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0;
        full_state = 0; rst_int_reg = 0; pkt_valid = 0; fifo_full = 0; data_in = 8'h00;
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
        pl[4] = 8'h55; pl[5] = 8'h00; pl[6] = 8'h00; pl[7] = 8'h00;
        @(posedge clock);
        #1;
        chk("rst_dout", dout, 8'h00);
        chk("rst_err", err, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_done", parity_done, 0);
        chk("rst_lpv", low_packet_valid, 0);
        reset = 1'b0;
        idle();

        // 16^11^22^33^44^55 = 07 ; odd seed gives F8
        send_pkt("t1_good",   8'h16, 5, 8'h07, -1, 0, 0, 1);
        send_pkt("t2_badpar", 8'h16, 5, 8'd46, -1, 1, 0, 1);
        send_pkt("t3_stall",  8'h16, 5, 8'h07,  2, 0, 0, 1);
        // 16^11^22^33^44 = 52 ; only 4 bytes against len 5
        send_pkt("t4_short",  8'h16, 4, 8'h52, -1, 0, 1, 1);

        // Illegal addr 3: header_reg keeps 16
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 8'h17);
        cyc(0, 1, 0, 0, 0, 0, 1, 0, 8'h17);
        chk("t5_hdr_kept", dout, 8'h16);
        cyc(0, 0, 1, 0, 0, 0, 1, 0, 8'h11);
        chk("t5_pl_dout", dout, 8'h11);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_dout", dout, 8'h00);
        chk("t5_async_dout_odd", dout_o, 8'h00);
        chk("t5_async_done", parity_done, 0);
        chk("t5_async_err", err, 0);
        chk("t5_async_len", len_err, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc(0, 1, 0, 0, 0, 0, 1, 0, 8'h00);
        chk("t5_hdr_cleared", dout, 8'h00);
        idle();

        send_pkt("t6_oddpar", 8'h16, 5, 8'hF8, -1, 1, 0, 0);
        // Zero length: parity = header; one stray byte flags len_err
        send_pkt("t7_zero",   8'h02, 0, 8'h02, -1, 0, 0, 1);
        send_pkt("t8_zero1",  8'h02, 1, 8'h13, -1, 0, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish, expected finish before 50000");
        $fatal(1);
    end

endmodule
